// File: rtl/vx_cmt_csr_pkg.sv
// Shared definitions for the commit-side CSR tracker: CSR addresses, the
// response state encoding and the TIMEIT_STATUS field layout.
package vx_cmt_csr_pkg;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_TIMEIT_START  = 12'h7C0;
    localparam logic [11:0] CSR_TIMEIT_END    = 12'h7C1;
    localparam logic [11:0] CSR_TIMEIT_CTRL   = 12'h7C2;
    localparam logic [11:0] CSR_TIMEIT_COUNT  = 12'h7C3;
    localparam logic [11:0] CSR_TIMEIT_STATUS = 12'h7C4;

    localparam int STATUS_ACT_LSB = 0;
    localparam int STATUS_OVF_LSB = 16;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_PEND = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/vx_timeit_counter.sv
// One warp's timeit window timer: clears on the rising edge of its active
// flag, counts while active, saturates and raises a sticky overflow flag.
module vx_timeit_counter (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_active,
    output logic [31:0] o_count,
    output logic        o_ovf
);

    logic        r_active_d;
    logic [31:0] r_count;
    logic        r_ovf;
    logic        w_rise;

    assign w_rise  = i_active & ~r_active_d;
    assign o_count = r_count;
    assign o_ovf   = r_ovf;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_active_d <= 1'b0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_active_d <= i_active;
            if (w_rise) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (i_active) begin
                // An increment attempted at the ceiling is what marks the overflow.
                if (r_count == 32'hFFFF_FFFF) r_ovf <= 1'b1;
                else                          r_count <= r_count + 32'd1;
            end
        end
    end

endmodule

// File: rtl/vx_commit_csr_tracker.sv
// CSR-side consumer of the commit interface: mcycle/minstret, timeit
// address/enable registers, per-warp timeit counters, 1-cycle CSR access.
module vx_commit_csr_tracker
    import vx_cmt_csr_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int CSZ_W     = 6,
    parameter int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmt_valid,
    input  logic [CSZ_W-1:0]     i_cmt_commit_size,
    input  logic [NUM_WARPS-1:0] i_timeit_active,
    output logic [31:0]          o_timeit_start_addr,
    output logic [31:0]          o_timeit_end_addr,
    output logic                 o_timeit_enable,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_write,
    input  logic [11:0]          i_req_addr,
    input  logic [NW_BITS-1:0]   i_req_wid,
    input  logic [31:0]          i_req_data,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rsp_data
);

    rsp_state_e  r_state, w_state_nxt;
    logic [63:0] r_mcycle, r_minstret;
    logic [31:0] r_mcycle_sh, r_minstret_sh;
    logic [31:0] r_start, r_end;
    logic        r_enable;
    logic [31:0] r_rsp_data;
    logic [31:0] w_rd_data;
    logic [31:0] w_status;
    logic        w_fire, w_wr, w_rd;
    logic [31:0]          w_count [NUM_WARPS];
    logic [NUM_WARPS-1:0] w_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_timeit
            vx_timeit_counter u_cnt (
                .i_clk    (i_clk),
                .i_reset  (i_reset),
                .i_active (i_timeit_active[gi]),
                .o_count  (w_count[gi]),
                .o_ovf    (w_ovf[gi])
            );
        end
    endgenerate

    assign o_rsp_valid         = (r_state == RSP_PEND);
    assign o_req_ready         = ~o_rsp_valid | i_rsp_ready;
    assign o_rsp_data          = r_rsp_data;
    assign o_timeit_start_addr = r_start;
    assign o_timeit_end_addr   = r_end;
    assign o_timeit_enable     = r_enable;

    assign w_fire = i_req_valid & o_req_ready;
    assign w_wr   = w_fire & i_req_write;
    assign w_rd   = w_fire & ~i_req_write;

    always_comb begin
        w_status = '0;
        w_status[STATUS_ACT_LSB +: NUM_WARPS] = i_timeit_active;
        w_status[STATUS_OVF_LSB +: NUM_WARPS] = w_ovf;
    end

    always_comb begin
        w_rd_data = '0;
        case (i_req_addr)
            CSR_MCYCLE:        w_rd_data = r_mcycle[31:0];
            CSR_MINSTRET:      w_rd_data = r_minstret[31:0];
            CSR_MCYCLEH:       w_rd_data = r_mcycle_sh;
            CSR_MINSTRETH:     w_rd_data = r_minstret_sh;
            CSR_TIMEIT_START:  w_rd_data = r_start;
            CSR_TIMEIT_END:    w_rd_data = r_end;
            CSR_TIMEIT_CTRL:   w_rd_data = {31'd0, r_enable};
            CSR_TIMEIT_COUNT:  w_rd_data = w_count[i_req_wid];
            CSR_TIMEIT_STATUS: w_rd_data = w_status;
            default:           w_rd_data = '0;
        endcase
    end

    // A software write to either half pre-empts that counter's increment for the cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mcycle      <= '0;
            r_minstret    <= '0;
            r_mcycle_sh   <= '0;
            r_minstret_sh <= '0;
            r_start       <= '0;
            r_end         <= '0;
            r_enable      <= 1'b0;
        end else begin
            if (w_wr && i_req_addr == CSR_MCYCLE)
                r_mcycle <= {r_mcycle[63:32], i_req_data};
            else if (w_wr && i_req_addr == CSR_MCYCLEH)
                r_mcycle <= {i_req_data, r_mcycle[31:0]};
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_wr && i_req_addr == CSR_MINSTRET)
                r_minstret <= {r_minstret[63:32], i_req_data};
            else if (w_wr && i_req_addr == CSR_MINSTRETH)
                r_minstret <= {i_req_data, r_minstret[31:0]};
            else if (i_cmt_valid)
                r_minstret <= r_minstret + 64'(i_cmt_commit_size);

            if (w_rd && i_req_addr == CSR_MCYCLE)   r_mcycle_sh   <= r_mcycle[63:32];
            if (w_rd && i_req_addr == CSR_MINSTRET) r_minstret_sh <= r_minstret[63:32];

            if (w_wr && i_req_addr == CSR_TIMEIT_START) r_start  <= i_req_data;
            if (w_wr && i_req_addr == CSR_TIMEIT_END)   r_end    <= i_req_data;
            if (w_wr && i_req_addr == CSR_TIMEIT_CTRL)  r_enable <= i_req_data[0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= RSP_IDLE;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) r_rsp_data <= i_req_write ? 32'd0 : w_rd_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RSP_IDLE: if (w_fire) w_state_nxt = RSP_PEND;
            RSP_PEND: if (i_rsp_ready && !w_fire) w_state_nxt = RSP_IDLE;
            default:  w_state_nxt = RSP_IDLE;
        endcase
    end

endmodule
